// File: rtl/dsp_sched_pkg.sv
// Shared types and helpers for the DSP time-sharing scheduler.
package dsp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HALF    = 2'd0;
  localparam logic [1:0] MODE_MIXED   = 2'd1;
  localparam logic [1:0] MODE_FULL    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int unsigned OCC_MAX = 4;

  // Cycles the DSP is busy for a given mode.
  function automatic logic [2:0] occ_cycles(input logic [1:0] mode);
    case (mode)
      MODE_HALF:  return 3'd1;
      MODE_MIXED: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester after 'last', wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant_c,
  output logic [IW-1:0]    idx_c,
  output logic             any_c
);

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!any_c && eligible[IW'((32'(last) + i) % N_REQ)]) begin
        grant_c[IW'((32'(last) + i) % N_REQ)] = 1'b1;
        idx_c = IW'((32'(last) + i) % N_REQ);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_share_sched.sv
// Time-shares one DSP among N_REQ requesters; one op in flight, MAC chains locked to one owner.
module dsp_share_sched
  import dsp_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_BITS = 2,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned PIPE_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [2*N_REQ-1:0]            req_mode,
  input  logic [N_REQ-1:0]              req_mac,
  input  logic [SHIFT_BITS*N_REQ-1:0]   req_shift_amount,
  input  logic [N_REQ-1:0]              req_shift_dir,
  input  logic [WIDTH*N_REQ-1:0]        req_aa,
  input  logic [WIDTH*N_REQ-1:0]        req_bb,
  input  logic [2*WIDTH*N_REQ-1:0]      req_cc,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(N_REQ)-1:0]      resp_id,
  output logic [2*WIDTH-1:0]            resp_data,
  output logic                          resp_err,
  output logic                          dsp_start,
  output logic                          dsp_mac,
  output logic                          dsp_shift_dir,
  output logic [1:0]                    dsp_mode,
  output logic [SHIFT_BITS-1:0]         dsp_shift_amount,
  output logic [WIDTH-1:0]              dsp_aa,
  output logic [WIDTH-1:0]              dsp_bb,
  output logic [2*WIDTH-1:0]            dsp_cc,
  input  logic [2*WIDTH-1:0]            dsp_out
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(OCC_MAX + PIPE_LAT + 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           last_q, last_d, lock_id_q, lock_id_d, resp_id_q, resp_id_d;
  logic                    locked_q, locked_d;
  logic                    resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [2*WIDTH-1:0]      resp_data_q, resp_data_d;
  logic                    dsp_start_q, dsp_start_d, dsp_mac_q, dsp_mac_d;
  logic                    dsp_shift_dir_q, dsp_shift_dir_d;
  logic [1:0]              dsp_mode_q, dsp_mode_d;
  logic [SHIFT_BITS-1:0]   dsp_shift_amount_q, dsp_shift_amount_d;
  logic [WIDTH-1:0]        dsp_aa_q, dsp_aa_d, dsp_bb_q, dsp_bb_d;
  logic [2*WIDTH-1:0]      dsp_cc_q, dsp_cc_d;

  logic [N_REQ-1:0]        lock_mask_c, elig_c, grant_c;
  logic [IW-1:0]           gidx_c;
  logic                    any_c;
  logic [1:0]              sel_mode_c;
  logic                    sel_mac_c, sel_shift_dir_c;
  logic [SHIFT_BITS-1:0]   sel_shift_amount_c;
  logic [WIDTH-1:0]        sel_aa_c, sel_bb_c;
  logic [2*WIDTH-1:0]      sel_cc_c;
  logic [CW-1:0]           tgt_c;

  // While locked, only the MAC chain owner may be granted.
  always_comb begin
    lock_mask_c            = '0;
    lock_mask_c[lock_id_q] = 1'b1;
    elig_c = locked_q ? (req_valid & lock_mask_c) : req_valid;
  end

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .eligible (elig_c),
    .last     (last_q),
    .grant_c  (grant_c),
    .idx_c    (gidx_c),
    .any_c    (any_c)
  );

  always_comb begin
    sel_mode_c         = '0;
    sel_mac_c          = 1'b0;
    sel_shift_dir_c    = 1'b0;
    sel_shift_amount_c = '0;
    sel_aa_c           = '0;
    sel_bb_c           = '0;
    sel_cc_c           = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        sel_mode_c         = req_mode[2*i +: 2];
        sel_mac_c          = req_mac[i];
        sel_shift_dir_c    = req_shift_dir[i];
        sel_shift_amount_c = req_shift_amount[SHIFT_BITS*i +: SHIFT_BITS];
        sel_aa_c           = req_aa[WIDTH*i +: WIDTH];
        sel_bb_c           = req_bb[WIDTH*i +: WIDTH];
        sel_cc_c           = req_cc[2*WIDTH*i +: 2*WIDTH];
      end
    end
  end

  // Last cycle of the ISSUE/WAIT window, counting ISSUE as cycle 0.
  assign tgt_c = CW'(32'(occ_cycles(dsp_mode_q)) + PIPE_LAT - 32'd1);

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    last_d             = last_q;
    lock_id_d          = lock_id_q;
    locked_d           = locked_q;
    resp_id_d          = resp_id_q;
    resp_valid_d       = resp_valid_q;
    resp_err_d         = resp_err_q;
    resp_data_d        = resp_data_q;
    dsp_start_d        = 1'b0;
    dsp_mac_d          = dsp_mac_q;
    dsp_shift_dir_d    = dsp_shift_dir_q;
    dsp_mode_d         = dsp_mode_q;
    dsp_shift_amount_d = dsp_shift_amount_q;
    dsp_aa_d           = dsp_aa_q;
    dsp_bb_d           = dsp_bb_q;
    dsp_cc_d           = dsp_cc_q;
    req_ready          = '0;

    case (state_q)
      IDLE: begin
        if (any_c) begin
          req_ready = grant_c;
          last_d    = gidx_c;
          resp_id_d = gidx_c;
          if (!sel_mac_c && locked_q && (gidx_c == lock_id_q)) locked_d = 1'b0;
          if (sel_mode_c == MODE_ILLEGAL) begin
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            if (sel_mac_c) begin
              locked_d  = 1'b1;
              lock_id_d = gidx_c;
            end
            resp_err_d         = 1'b0;
            dsp_start_d        = 1'b1;
            dsp_mode_d         = sel_mode_c;
            dsp_mac_d          = sel_mac_c;
            dsp_shift_dir_d    = sel_shift_dir_c;
            dsp_shift_amount_d = sel_shift_amount_c;
            dsp_aa_d           = sel_aa_c;
            dsp_bb_d           = sel_bb_c;
            dsp_cc_d           = sel_cc_c;
            cnt_d              = '0;
            state_d            = ISSUE;
          end
        end
      end
      ISSUE, WAIT: begin
        if (cnt_q == tgt_c) begin
          resp_data_d  = dsp_out;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      last_q             <= IW'(N_REQ - 1);
      lock_id_q          <= '0;
      locked_q           <= 1'b0;
      resp_id_q          <= '0;
      resp_valid_q       <= 1'b0;
      resp_err_q         <= 1'b0;
      resp_data_q        <= '0;
      dsp_start_q        <= 1'b0;
      dsp_mac_q          <= 1'b0;
      dsp_shift_dir_q    <= 1'b0;
      dsp_mode_q         <= '0;
      dsp_shift_amount_q <= '0;
      dsp_aa_q           <= '0;
      dsp_bb_q           <= '0;
      dsp_cc_q           <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      last_q             <= last_d;
      lock_id_q          <= lock_id_d;
      locked_q           <= locked_d;
      resp_id_q          <= resp_id_d;
      resp_valid_q       <= resp_valid_d;
      resp_err_q         <= resp_err_d;
      resp_data_q        <= resp_data_d;
      dsp_start_q        <= dsp_start_d;
      dsp_mac_q          <= dsp_mac_d;
      dsp_shift_dir_q    <= dsp_shift_dir_d;
      dsp_mode_q         <= dsp_mode_d;
      dsp_shift_amount_q <= dsp_shift_amount_d;
      dsp_aa_q           <= dsp_aa_d;
      dsp_bb_q           <= dsp_bb_d;
      dsp_cc_q           <= dsp_cc_d;
    end
  end

  assign resp_valid       = resp_valid_q;
  assign resp_id          = resp_id_q;
  assign resp_data        = resp_data_q;
  assign resp_err         = resp_err_q;
  assign dsp_start        = dsp_start_q;
  assign dsp_mac          = dsp_mac_q;
  assign dsp_shift_dir    = dsp_shift_dir_q;
  assign dsp_mode         = dsp_mode_q;
  assign dsp_shift_amount = dsp_shift_amount_q;
  assign dsp_aa           = dsp_aa_q;
  assign dsp_bb           = dsp_bb_q;
  assign dsp_cc           = dsp_cc_q;

endmodule
